// File: rtl/adex_pkg.sv
// Shared constants for the AdEx nibble parameter-load protocol (transmitter and neuron loader).
package adex_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [3:0] FOOTER_NIB     = 4'hF;
  localparam int         NUM_PARAMS     = 7;
  localparam int         NIBS_PER_FRAME = 2 * NUM_PARAMS;
  localparam logic [3:0] SYM_LAST       = 4'(NIBS_PER_FRAME + 1);

  localparam int IDX_DELTAT = 0;
  localparam int IDX_TAUW   = 1;
  localparam int IDX_A      = 2;
  localparam int IDX_B      = 3;
  localparam int IDX_VRESET = 4;
  localparam int IDX_VT     = 5;
  localparam int IDX_IBIAS  = 6;

  // Symbol 0 is the header, 1..14 carry data high nibble first, 15 is the footer.
  function automatic logic [3:0] sym_nibble(input logic [55:0] p, input logic [3:0] s,
                                            input logic [3:0] footer);
    logic [2:0] idx;
    logic [7:0] b;
    idx = 3'((s - 4'd1) >> 1);
    b   = 8'(p >> {idx, 3'b000});
    if (s == 4'd0)          return 4'h0;
    else if (s == SYM_LAST) return footer;
    else if (s[0])          return b[7:4];
    else                    return b[3:0];
  endfunction

endpackage

// File: rtl/adex_nib_strobe.sv
// Per-symbol SETUP/HIGH/LOW sequencer: holds a nibble and pulses load_enable around it.
module adex_nib_strobe #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HIGH_CYC  = 2,
  parameter int unsigned LOW_CYC   = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       clr,
  input  logic [3:0] nib,
  output logic       load_enable,
  output logic [3:0] nibble,
  output logic       sym_done
);
  import adex_pkg::*;

  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LOW_CYC - 1);

  logic [2:0]       phase;
  logic [CNT_W-1:0] cnt;

  // Combinational so the next symbol's SETUP starts right after the last LOW cycle.
  assign sym_done = (phase == ST_LOW) && (cnt == L_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= ST_IDLE;
      cnt         <= '0;
      load_enable <= 1'b0;
      nibble      <= 4'h0;
    end else if (clr) begin
      phase       <= ST_IDLE;
      cnt         <= '0;
      load_enable <= 1'b0;
      nibble      <= 4'h0;
    end else if (go) begin
      phase       <= ST_SETUP;
      cnt         <= '0;
      load_enable <= 1'b0;
      nibble      <= nib;
    end else begin
      case (phase)
        ST_SETUP: if (cnt == S_LAST) begin
                    phase <= ST_HIGH; cnt <= '0; load_enable <= 1'b1;
                  end else cnt <= cnt + 1'b1;
        ST_HIGH:  if (cnt == H_LAST) begin
                    phase <= ST_LOW; cnt <= '0; load_enable <= 1'b0;
                  end else cnt <= cnt + 1'b1;
        ST_LOW:   if (cnt == L_LAST) begin
                    phase <= ST_IDLE; cnt <= '0; nibble <= 4'h0;
                  end else cnt <= cnt + 1'b1;
        default:  cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/adex_param_nibble_tx.sv
// Host-side AdEx parameter frame transmitter. Optional abort port pair under `ADEX_TX_ABORT_EN.
module adex_param_nibble_tx #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned HIGH_CYC   = 2,
  parameter int unsigned LOW_CYC    = 2,
  parameter int unsigned HOLD_CYC   = 4,
  parameter logic [3:0]  FOOTER_NIB = 4'hF,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [55:0] params_flat,
`ifdef ADEX_TX_ABORT_EN
  input  logic        abort,
  output logic        aborted,
`endif
  output logic        load_mode,
  output logic        load_enable,
  output logic [3:0]  nibble,
  output logic        busy,
  output logic        done
);
  import adex_pkg::*;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  // ST_SETUP here spans a whole symbol; the strobe sub-module sequences SETUP/HIGH/LOW.
  logic [2:0]       state;
  logic [3:0]       sym;
  logic [55:0]      shadow;
  logic [CNT_W-1:0] hcnt;
  logic             go, clr, sym_done;
  logic [3:0]       nib;

`ifdef ADEX_TX_ABORT_EN
  assign clr = abort && (state != ST_IDLE);
`else
  assign clr = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    go  = 1'b0;
    nib = 4'h0;
    if (state == ST_IDLE) begin
      go = start;
    end else if (state == ST_SETUP && sym_done && sym != SYM_LAST) begin
      go  = 1'b1;
      nib = sym_nibble(shadow, sym + 4'd1, FOOTER_NIB);
    end
  end

  adex_nib_strobe #(
    .SETUP_CYC(SETUP_CYC), .HIGH_CYC(HIGH_CYC), .LOW_CYC(LOW_CYC), .CNT_W(CNT_W)
  ) u_strobe (
    .clk(clk), .rst_n(rst_n), .go(go), .clr(clr), .nib(nib),
    .load_enable(load_enable), .nibble(nibble), .sym_done(sym_done)
  );

  // NOTE: the shadow register is a single flop vector, so it is cleared on reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sym       <= 4'd0;
      shadow    <= '0;
      hcnt      <= '0;
      load_mode <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ADEX_TX_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ADEX_TX_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        ST_IDLE: if (start) begin
                   shadow    <= params_flat;
                   state     <= ST_SETUP;
                   sym       <= 4'd0;
                   load_mode <= 1'b1;
                   busy      <= 1'b1;
                 end
        ST_SETUP: if (sym_done) begin
                    if (sym == SYM_LAST) begin
                      state <= ST_HOLD;
                      hcnt  <= '0;
                    end else sym <= sym + 4'd1;
                  end
        ST_HOLD: if (hcnt == HOLD_LAST) begin
                   state     <= ST_DONE;
                   load_mode <= 1'b0;
                   busy      <= 1'b0;
                   done      <= 1'b1;
                 end else hcnt <= hcnt + 1'b1;
        default: state <= ST_IDLE;
      endcase
`ifdef ADEX_TX_ABORT_EN
      if (clr) begin
        state     <= ST_IDLE;
        load_mode <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
        aborted   <= 1'b1;
      end
`endif
    end
  end

endmodule
